// File: rtl/serdes_err_inject_loopback.sv
// SERDES loopback with burst/periodic error injection on the sync header and data.
// Latency: DELAY cycles, in to out. Backpressure: none; one block accepted and emitted every cycle.
// Corruption is decided as the block enters, and the corruption flag travels with the block.
module serdes_err_inject_loopback #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int DELAY      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    input  logic [1:0]            cfg_mode,
    input  logic [HDR_WIDTH-1:0]  cfg_hdr_value,
    input  logic [DATA_WIDTH-1:0] cfg_data_mask,
    input  logic [CNT_WIDTH-1:0]  cfg_burst_len,
    input  logic [CNT_WIDTH-1:0]  cfg_period,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  inject_active,
    output logic [CNT_WIDTH-1:0]  inject_count
);
    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    state_t                 state, state_nxt;
    logic [1:0]             mode_q;
    logic [HDR_WIDTH-1:0]   hdr_val_q;
    logic [DATA_WIDTH-1:0]  mask_q;
    logic [CNT_WIDTH-1:0]   burst_q, period_q, cnt_q;
    logic [CNT_WIDTH-1:0]   eff_burst, gap_len;
    logic                   start_ok, burst_done, gap_done, has_gap;
    logic                   corrupt, busy_nxt;

    logic [DATA_WIDTH-1:0]  pipe_data [DELAY];
    logic [HDR_WIDTH-1:0]   pipe_hdr  [DELAY];
    logic                   pipe_inj  [DELAY];

    // stop outranks start, so a simultaneous pair never leaves IDLE
    assign start_ok   = start && !stop && (cfg_mode == 2'd1 || cfg_mode == 2'd2);
    assign eff_burst  = (burst_q == '0) ? ONE : burst_q;
    assign has_gap    = period_q > eff_burst;
    assign gap_len    = period_q - eff_burst;
    assign burst_done = cnt_q == eff_burst - ONE;
    assign gap_done   = cnt_q == gap_len - ONE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = BURST;
            BURST: begin
                if (stop)
                    state_nxt = IDLE;
                else if (burst_done)
                    state_nxt = (mode_q == 2'd2) ? (has_gap ? GAP : BURST) : IDLE;
            end
            GAP: begin
                if (stop)          state_nxt = IDLE;
                else if (gap_done) state_nxt = BURST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        corrupt  = 1'b0;
        busy_nxt = 1'b0;
        if (state == BURST)    corrupt  = 1'b1;
        if (state_nxt != IDLE) busy_nxt = 1'b1;
    end

    // Block counter restarts at every phase boundary, including back-to-back bursts
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (state == IDLE || state_nxt != state || (state == BURST && burst_done))
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= '0;
            hdr_val_q <= '0;
            mask_q    <= '0;
            burst_q   <= '0;
            period_q  <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (state == IDLE && start_ok) begin
                mode_q    <= cfg_mode;
                hdr_val_q <= cfg_hdr_value;
                mask_q    <= cfg_data_mask;
                burst_q   <= cfg_burst_len;
                period_q  <= cfg_period;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_data[i] <= '0;
                pipe_hdr[i]  <= '0;
                pipe_inj[i]  <= 1'b0;
            end
        end else begin
            pipe_data[0] <= corrupt ? (in_data ^ mask_q) : in_data;
            pipe_hdr[0]  <= corrupt ? hdr_val_q : in_hdr;
            pipe_inj[0]  <= corrupt;
            for (int i = 1; i < DELAY; i++) begin
                pipe_data[i] <= pipe_data[i-1];
                pipe_hdr[i]  <= pipe_hdr[i-1];
                pipe_inj[i]  <= pipe_inj[i-1];
            end
        end
    end

    assign out_data      = pipe_data[DELAY-1];
    assign out_hdr       = pipe_hdr[DELAY-1];
    assign inject_active = pipe_inj[DELAY-1];

    always_ff @(posedge clk) begin
        if (rst)
            inject_count <= '0;
        else if (inject_active && inject_count != '1)
            inject_count <= inject_count + ONE;
    end
endmodule
